// File: rtl/debug_display_scanner_if.sv
// Signal bundle between the debug display scanner and its board-side driver.
// The master drives channel data, mode and controls. The slave returns segments and index.
interface debug_display_scanner_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 32,
    parameter int NUM_DIGITS = 8
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]        aux_data;
    logic [1:0]               mode;
    logic [SEL_W-1:0]         sw_sel;
    logic                     step_btn;
    logic                     hold;
    logic [NUM_DIGITS*7-1:0]  hex_seg;
    logic [SEL_W-1:0]         cur_index;
    logic                     scan_tick;

    modport master (
        output ch_data, aux_data, mode, sw_sel, step_btn, hold,
        input  hex_seg, cur_index, scan_tick
    );

    modport slave (
        input  ch_data, aux_data, mode, sw_sel, step_btn, hold,
        output hex_seg, cur_index, scan_tick
    );
endinterface

// File: rtl/debug_display_scanner.sv
// Debug monitor that selects a channel word or aux word and drives active-low hex digits.
// The index is set manually, auto-scanned, or stepped by a debounced button.
module debug_display_scanner #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input logic                    clk,
    input logic                    reset,
    debug_display_scanner_if.slave bus
);
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PAD_W   = ((DATA_W + 3) / 4) * 4;

    localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]     NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_AUX    = 2'b11
    } mode_t;

    mode_t mode;
    assign mode = mode_t'(bus.mode);

    logic [SEL_W-1:0]        index_reg, index_next, index_inc;
    logic [PRESC_W-1:0]      presc_reg, presc_next;
    logic                    tick_reg, tick_next;
    logic                    sync1_reg, sync2_reg, deb_state_reg;
    logic [DEB_W-1:0]        deb_cnt_reg;
    logic                    deb_diff, deb_done, deb_rise;
    logic [DATA_W-1:0]       disp_val_reg, src;
    logic [PAD_W-1:0]        disp_pad;
    logic [NUM_DIGITS*7-1:0] seg_next, hex_seg_reg;
    logic [DATA_W-1:0]       ch_words [NUM_CH];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_words[gi] = bus.ch_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The button counts as settled only after it disagrees with the debounced state long enough.
    assign deb_diff  = sync2_reg ^ deb_state_reg;
    assign deb_done  = deb_diff && (deb_cnt_reg == DEB_LAST);
    assign deb_rise  = deb_done && sync2_reg;
    assign index_inc = (index_reg == LAST_IDX) ? '0 : index_reg + SEL_W'(1);

    always_comb begin
        index_next = index_reg;
        presc_next = '0;
        tick_next  = 1'b0;
        case (mode)
            MODE_MANUAL: index_next = ({1'b0, bus.sw_sel} >= NUM_CH_EXT) ? LAST_IDX : bus.sw_sel;
            MODE_AUTO: begin
                if (presc_reg == PRESC_LAST) begin
                    index_next = index_inc;
                    tick_next  = 1'b1;
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end
            MODE_STEP: begin
                if (deb_rise) begin
                    index_next = index_inc;
                    tick_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_reg     <= '0;
            presc_reg     <= '0;
            tick_reg      <= 1'b0;
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            deb_state_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            index_reg <= index_next;
            presc_reg <= presc_next;
            tick_reg  <= tick_next;
            sync1_reg <= bus.step_btn;
            sync2_reg <= sync1_reg;
            if (!deb_diff || deb_done) begin
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
            if (deb_done) begin
                deb_state_reg <= sync2_reg;
            end
        end
    end

    assign src      = (mode == MODE_AUX) ? bus.aux_data : ch_words[index_reg];
    assign disp_pad = PAD_W'(disp_val_reg);

    // Digits beyond the data width stay blank; a partial top nibble reads zero-extended.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (4 * gi >= DATA_W) begin : g_blank
                assign seg_next[gi*7 +: 7] = 7'h7F;
            end else begin : g_hex
                assign seg_next[gi*7 +: 7] = hex7(disp_pad[gi*4 +: 4]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_val_reg <= '0;
            hex_seg_reg  <= '1;
        end else begin
            if (!bus.hold) begin
                disp_val_reg <= src;
            end
            hex_seg_reg <= seg_next;
        end
    end

    assign bus.hex_seg   = hex_seg_reg;
    assign bus.cur_index = index_reg;
    assign bus.scan_tick = tick_reg;
endmodule
